// File: rtl/prbs7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs7_pkg
//  Description : Shared definitions for the PRBS7 generator and checker.
//                Holds the polynomial taps, word geometry, the substitute
//                for an all-zero seed and the controller state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package prbs7_pkg;

    // Word geometry
    localparam int unsigned c_WORD_W    = 64;
    localparam int unsigned c_LFSR_W    = 7;
    localparam int unsigned c_MASK_W    = 16;
    localparam int unsigned c_MASK_REPS = c_WORD_W / c_MASK_W;

    // x^7 + x^6 + 1  ->  b[n] = b[n-6] ^ b[n-7]
    localparam int unsigned c_TAP_A = 6;
    localparam int unsigned c_TAP_B = 7;

    // An all-zero LFSR never leaves zero, so that seed is replaced.
    localparam logic [c_LFSR_W-1:0] c_ZERO_SEED_SUB = 7'h7F;

    // Controller states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    function automatic logic [c_LFSR_W-1:0] fixSeed(input logic [c_LFSR_W-1:0] s);
        return (s == '0) ? c_ZERO_SEED_SUB : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs7_step.sv
`default_nettype none
// ============================================================================
//  Module      : prbs7_step
//  Description : Combinational 64-bit PRBS7 advance. Given the last seven
//                bits of the stream, produces the next 64 bits (bit 0 is the
//                earliest in time) and the resulting seven-bit history.
//  Ports       : i_state     - history, bit 0 oldest, bit 6 newest
//                o_word      - next 64 stream bits, LSB first in time
//                o_nextState - history after the word (= o_word[63:57])
//  Revision    : 1.0  initial release
// ============================================================================
module prbs7_step
    import prbs7_pkg::*;
(
    input  logic [c_LFSR_W-1:0] i_state,
    output logic [c_WORD_W-1:0] o_word,
    output logic [c_LFSR_W-1:0] o_nextState
);

    logic [c_LFSR_W-1:0] w_hist;
    logic                w_bit;

    // Walk a sliding seven-bit history window; index 0 is the oldest bit,
    // so tap distance d sits at index c_LFSR_W - d.
    always_comb begin
        w_hist = i_state;
        w_bit  = 1'b0;
        o_word = '0;
        for (int k = 0; k < c_WORD_W; k++) begin
            w_bit     = w_hist[c_LFSR_W - c_TAP_A] ^ w_hist[c_LFSR_W - c_TAP_B];
            o_word[k] = w_bit;
            w_hist    = {w_bit, w_hist[c_LFSR_W-1:1]};
        end
    end

    // The newest seven bits become the next history, so a receiver can
    // re-seed from bits [63:57] of the word it just received.
    assign o_nextState = o_word[c_WORD_W-1 -: c_LFSR_W];

endmodule
`default_nettype wire

// File: rtl/prbs7_gen.sv
`default_nettype none
// ============================================================================
//  Module      : prbs7_gen
//  Description : 64-bit-per-cycle PRBS7 pattern generator with user-data
//                overlay, single-bit error injection and a valid/ready
//                output handshake.
//  Ports       : clk         - clock, rising edge
//                reset       - asynchronous active-low reset
//                seed        - LFSR seed, taken in LOAD (0 -> 7'h7F)
//                start/stop  - level controls for IDLE->LOAD / RUN->IDLE
//                mask        - 16-bit user mask, replicated across the word
//                user_word   - data XORed onto masked positions
//                inject_err  - request to flip bit inject_sel of next word
//                inject_sel  - bit index to flip
//                dout        - output word, bit 0 earliest in time
//                dout_valid  - dout holds a word
//                dout_ready  - sink accepts dout
//                word_count  - words accepted since LOAD (wraps)
//                inj_count   - flipped words accepted since reset (saturates)
//                busy        - high in LOAD and RUN
//  Revision    : 1.0  initial release
// ============================================================================
module prbs7_gen
    import prbs7_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [c_LFSR_W-1:0] seed,
    input  logic                start,
    input  logic                stop,
    input  logic [c_MASK_W-1:0] mask,
    input  logic [c_WORD_W-1:0] user_word,
    input  logic                inject_err,
    input  logic [5:0]          inject_sel,
    output logic [c_WORD_W-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [31:0]         word_count,
    output logic [15:0]         inj_count,
    output logic                busy
);

    logic [1:0]          r_state;
    logic [1:0]          w_stateNext;
    logic [c_LFSR_W-1:0] r_lfsr;
    logic [c_WORD_W-1:0] r_dout;
    logic                r_doutValid;
    logic                r_doutInj;
    logic [31:0]         r_wordCount;
    logic [15:0]         r_injCount;
    logic                r_injPend;
    logic [5:0]          r_injSel;

    logic [c_WORD_W-1:0] w_prbsWord;
    logic [c_LFSR_W-1:0] w_lfsrNext;
    logic [c_WORD_W-1:0] w_injVec;
    logic                w_accept;
    logic                w_canLoad;
    logic                w_loadWord;

    prbs7_step u_step (
        .i_state     (r_lfsr),
        .o_word      (w_prbsWord),
        .o_nextState (w_lfsrNext)
    );

    assign w_accept  = r_doutValid && dout_ready;
    // The output slot is free when empty or being drained this cycle.
    assign w_canLoad = !r_doutValid || dout_ready;
    assign w_injVec  = r_injPend ? ({{(c_WORD_W-1){1'b0}}, 1'b1} << r_injSel) : '0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_loadWord  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_stateNext = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_stateNext = c_ST_RUN;
            end
            c_ST_RUN: begin
                // Stop only takes effect once nothing is left to deliver;
                // no fresh word is produced on the way out.
                if (w_canLoad) begin
                    if (stop) begin
                        w_stateNext = c_ST_IDLE;
                    end else begin
                        w_loadWord = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_lfsr      <= c_ZERO_SEED_SUB;
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_doutInj   <= 1'b0;
            r_wordCount <= '0;
            r_injCount  <= '0;
            r_injPend   <= 1'b0;
            r_injSel    <= '0;
        end else begin
            r_state <= w_stateNext;

            // The LFSR only ever advances from the pure PRBS word, so
            // overlay and injection never disturb the sequence.
            if (r_state == c_ST_LOAD) begin
                r_lfsr <= fixSeed(seed);
            end else if (w_loadWord) begin
                r_lfsr <= w_lfsrNext;
            end

            if (w_loadWord) begin
                r_dout      <= w_prbsWord ^ (user_word & {c_MASK_REPS{mask}}) ^ w_injVec;
                r_doutValid <= 1'b1;
                r_doutInj   <= r_injPend;
            end else if (w_accept) begin
                r_doutValid <= 1'b0;
            end

            if (r_state == c_ST_LOAD) begin
                r_wordCount <= '0;
            end else if (w_accept) begin
                r_wordCount <= r_wordCount + 32'd1;
            end

            if (w_accept && r_doutInj && (r_injCount != 16'hFFFF)) begin
                r_injCount <= r_injCount + 16'd1;
            end

            // One outstanding request at most; extras are dropped.
            if (w_loadWord && r_injPend) begin
                r_injPend <= 1'b0;
            end else if (inject_err && !r_injPend) begin
                r_injPend <= 1'b1;
                r_injSel  <= inject_sel;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_doutValid;
    assign word_count = r_wordCount;
    assign inj_count  = r_injCount;
    assign busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_prbs7_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs7_gen
//  Description : Self-checking bench for prbs7_gen. Expected words come from
//                a bit-serial stream model; a monitor compares every
//                presented word against the head of the expected queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prbs7_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  seed = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] mask = '0;
    logic [63:0] user_word = '0;
    logic        inject_err = 1'b0;
    logic [5:0]  inject_sel = '0;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [31:0] word_count;
    logic [15:0] inj_count;
    logic        busy;

    prbs7_gen dut (
        .clk        (clk),
        .reset      (reset),
        .seed       (seed),
        .start      (start),
        .stop       (stop),
        .mask       (mask),
        .user_word  (user_word),
        .inject_err (inject_err),
        .inject_sel (inject_sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .word_count (word_count),
        .inj_count  (inj_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] expQ[$];
    logic [63:0] firstWord = '0;
    bit          firstPending = 1'b0;
    logic [63:0] lbMaskVec = '0;
    int          lbErr = 0;
    logic [6:0]  lbPrev = '0;
    bit          lbPrevOk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bit-serial reference: extend a bit stream by b[n] = b[n-6] ^ b[n-7],
    // starting from seven history bits (bit 0 oldest).
    function automatic logic [63:0] serialWord(input logic [6:0] hist);
        bit          q[$];
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 7; i++) q.push_back(hist[i]);
        for (int k = 0; k < 64; k++) begin
            q.push_back(q[$-5] ^ q[$-6]);
            w[k] = q[$];
        end
        return w;
    endfunction

    // Monitor / scoreboard plus a loopback checker that predicts each word
    // from the previous received bits [63:57].
    always @(negedge clk) begin
        logic [63:0] exp;
        logic [63:0] pred;
        if (!reset) begin
            lbPrevOk = 1'b0;
        end else begin
            if (dout_valid) begin
                if (expQ.size() == 0) begin
                    check("unexpected_word", dout, 64'hx);
                end else begin
                    exp = expQ[0];
                    check("word", dout, exp);
                    if (dout_ready) begin
                        void'(expQ.pop_front());
                        if (firstPending) begin
                            firstWord    = dout;
                            firstPending = 1'b0;
                        end
                        if (lbPrevOk) begin
                            pred  = serialWord(lbPrev);
                            lbErr = lbErr + $countones((dout ^ pred) & ~lbMaskVec);
                        end
                        lbPrev   = dout[63:57];
                        lbPrevOk = 1'b1;
                    end
                end
            end
            if (!busy) lbPrevOk = 1'b0;
        end
    end

    task automatic runPhase(input logic [6:0] sd, input int n, input int readyPct,
                            input logic [15:0] mk, input logic [63:0] uw,
                            input bit doStall, input bit doInj, input int abortAt);
        logic [6:0]  hist;
        logic [63:0] w;
        int          acc;
        int          cyc;
        bit          stallDone;
        bit          injDone;
        acc = 0; cyc = 0; stallDone = 1'b0; injDone = 1'b0;

        seed = sd; mask = mk; user_word = uw;
        lbMaskVec = {4{mk}};
        lbErr = 0;
        hist = (sd == 7'h00) ? 7'h7F : sd;
        for (int i = 0; i < n; i++) begin
            w = serialWord(hist);
            expQ.push_back(w ^ (uw & {4{mk}}));
            hist = w[63:57];
        end
        firstPending = 1'b1;

        @(posedge clk); #1;
        start = 1'b1;
        dout_ready = (int'($urandom_range(99)) < readyPct);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("load_busy", 64'(busy), 64'd1);
        check("load_valid", 64'(dout_valid), 64'd0);
        @(negedge clk);
        check("run1_valid", 64'(dout_valid), 64'd0);
        @(negedge clk);
        check("first_valid", 64'(dout_valid), 64'd1);

        while (cyc < n * 20 + 200) begin
            if (dout_valid && dout_ready) begin
                acc++;
                if (acc == n) stop = 1'b1;
            end
            if (acc == n) break;
            @(posedge clk); #1;
            if (abortAt > 0 && acc >= abortAt) begin
                dout_ready = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check("rst_valid", 64'(dout_valid), 64'd0);
                check("rst_wcount", 64'(word_count), 64'd0);
                check("rst_icount", 64'(inj_count), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_dout", dout, 64'd0);
                expQ.delete();
                @(posedge clk); #1;
                reset = 1'b1;
                return;
            end else if (doStall && !stallDone && acc >= 10) begin
                dout_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("stall_valid", 64'(dout_valid), 64'd1);
                    check("stall_wcount", 64'(word_count), 64'(acc));
                    @(posedge clk); #1;
                end
                stallDone = 1'b1;
                dout_ready = 1'b1;
            end else if (doInj && !injDone && acc >= 20 && acc < n - 2) begin
                dout_ready = 1'b0;
                inject_err = 1'b1;
                inject_sel = 6'd10;
                // Head of queue is on dout now; the next loaded word takes the flip.
                expQ[1][10] = ~expQ[1][10];
                @(posedge clk); #1;
                inject_err = 1'b0;
                @(posedge clk); #1;
                inject_err = 1'b1;
                inject_sel = 6'd20;
                @(posedge clk); #1;
                inject_err = 1'b0;
                injDone = 1'b1;
                dout_ready = (int'($urandom_range(99)) < readyPct);
            end else begin
                dout_ready = (int'($urandom_range(99)) < readyPct);
            end
            @(negedge clk);
            cyc++;
        end

        if (acc != n) begin
            check("phase_timeout", 64'(acc), 64'(n));
            stop = 1'b1;
            dout_ready = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            stop = 1'b0;
            expQ.delete();
            return;
        end

        @(negedge clk);
        check("end_valid", 64'(dout_valid), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        check("end_wcount", 64'(word_count), 64'(n));
        check("end_queue", 64'(expQ.size()), 64'd0);
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dout", dout, 64'd0);
        check("reset_valid", 64'(dout_valid), 64'd0);
        check("reset_wcount", 64'(word_count), 64'd0);
        check("reset_icount", 64'(inj_count), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Long run, seed 7F, sink always ready
        runPhase(7'h7F, 1000, 100, 16'h0000, 64'd0, 1'b0, 1'b0, 0);
        check("seed7f_first_bits", 64'(firstWord[6:0]), 64'(7'b1000000));

        // Zero seed behaves as 7F; includes a 5-cycle stall
        runPhase(7'h00, 50, 70, 16'h0000, 64'd0, 1'b1, 1'b0, 0);
        check("seed00_first_bits", 64'(firstWord[6:0]), 64'(7'b1000000));

        // Error injection with a dropped second request
        runPhase(7'($urandom_range(1, 127)), 60, 60, 16'h0000, 64'd0, 1'b0, 1'b1, 0);
        check("inj_count", 64'(inj_count), 64'd1);

        // User overlay on bits 7/23/39/55; loopback must see clean PRBS
        runPhase(7'($urandom_range(1, 127)), 40, 80, 16'h0080, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0);
        check("loopback_errors", 64'(lbErr), 64'd0);

        // Random overlay pattern with a stall
        runPhase(7'($urandom_range(0, 127)), 40, 50, 16'($urandom), {$urandom, $urandom}, 1'b1, 1'b0, 0);

        // Reset during a stall, then restart
        runPhase(7'h7F, 30, 100, 16'h0000, 64'd0, 1'b0, 1'b0, 8);
        runPhase(7'h7F, 5, 100, 16'h0000, 64'd0, 1'b0, 1'b0, 0);
        check("restart_first_bits", 64'(firstWord[6:0]), 64'(7'b1000000));
        check("restart_icount", 64'(inj_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs7_gen.md
PRBS7_GEN -- requirements
Module: prbs7_gen

Interface
REQ-001 SHALL expose: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL expose: reset  in  1  asynchronous, active-low reset (asserts immediately; deasserts synchronously to clk outside this block).
REQ-003 SHALL expose: seed  in  7  LFSR seed, sampled in LOAD.
REQ-004 SHALL expose: start  in  1  level; begins generation from IDLE.
REQ-005 SHALL expose: stop  in  1  level; returns to IDLE after the current word completes.
REQ-006 SHALL expose: mask  in  16  user-bit mask, replicated 4x across the word.
REQ-007 SHALL expose: user_word  in  64  user data XORed onto masked positions.
REQ-008 SHALL expose: inject_err  in  1  single-cycle request to flip one bit.
REQ-009 SHALL expose: inject_sel  in  6  bit index flipped on injection.
REQ-010 SHALL expose: dout  out  64  transmitted word; bit 0 is the earliest bit in time.
REQ-011 SHALL expose: dout_valid  out  1  dout holds a valid word.
REQ-012 SHALL expose: dout_ready  in  1  sink accepts dout when high with dout_valid.
REQ-013 SHALL expose: word_count  out  32  accepted words since LOAD, wraps at 2^32.
REQ-014 SHALL expose: inj_count  out  16  injected errors since reset, saturates at 16'hFFFF.
REQ-015 SHALL expose: busy  out  1  high in LOAD and RUN.

Function
REQ-016 Polynomial SHALL be x^7+x^6+1: b[n] = b[n-6] ^ b[n-7], computed 64 bits per cycle, LSB first.
REQ-017 The 7-bit state after each word SHALL equal that word's pure-PRBS bits [63:57], so a downstream checker that predicts each word from the previous received bits [63:57] locks after one word.
REQ-018 FSM states SHALL be IDLE, LOAD and RUN; IDLE->LOAD on start; LOAD->RUN unconditionally; RUN->IDLE when stop is high and no word is pending (dout_valid low, or accepted in that cycle).
REQ-019 In LOAD the state SHALL be set to seed; seed 7'h00 SHALL be replaced by 7'h7F.
REQ-020 The first dout_valid SHALL assert on the 2nd clock edge after start is sampled high in IDLE; that word SHALL be the 64 bits following the seed.
REQ-021 dout = prbs_word ^ (user_word & {4{mask}}) ^ inj_vector; LFSR state SHALL advance from the unmodified prbs_word only.
REQ-022 While dout_valid && !dout_ready, dout, dout_valid and the LFSR state SHALL hold unchanged; the next word SHALL be presented in the cycle after acceptance, giving 1 word/cycle with ready held high.
REQ-023 inject_err SHALL set a pending flag and latch inject_sel; the flag SHALL apply to the next newly loaded dout word only, then clear; requests arriving while a request is pending SHALL be dropped and not counted.
REQ-024 inj_count SHALL increment when a flipped word is accepted.
REQ-025 word_count SHALL increment on each dout_valid && dout_ready, and clear in LOAD.
REQ-026 In IDLE, dout_valid SHALL be 0 and dout SHALL hold its last value; start and stop both high in IDLE SHALL enter LOAD, and stop SHALL then be honoured in RUN.

Reset
REQ-027 On reset low, SHALL force: state IDLE, LFSR 7'h7F, dout 0, dout_valid 0, word_count 0, inj_count 0, pending flag 0, busy 0, including mid-word or during a stall; the partial word is discarded.

Structure
REQ-028 The polynomial taps, the zero-seed substitute 7'h7F, the FSM state encoding and the word width 64 SHALL live in a shared prbs7 package, so checker and generator share them.
REQ-029 The combinational 64-bit step SHALL be one sub-module, prbs7_step (7-bit state in, 64-bit word and next state out), reusable by the checker.

Verification
REQ-030 Seed 7'h7F, start, ready=1 -> first word bits[6:0]=7'b1000000; stream matches a bit-serial reference model for 1000 words; word_count=1000.
REQ-031 Seed 7'h00 -> output identical to seed 7'h7F.
REQ-032 Ready low for 5 cycles mid-stream -> dout stable for those cycles, no word skipped or repeated, word_count unchanged during the stall.
REQ-033 inject_err with inject_sel=6'd10, then a second pulse while the first is pending -> exactly one accepted word differs from the model, at bit 10 only; inj_count=1; following words are clean.
REQ-034 mask=16'h0080, user_word=64'hFFFF_FFFF_FFFF_FFFF -> bits 7, 23, 39, 55 inverted vs the model; a loopback checker reports 0 PRBS errors.
REQ-035 Reset asserted during a stall in RUN -> next cycle dout_valid=0, counters 0, state IDLE; a restart reproduces the first word of REQ-030.
